fd_pipe_reg: RTL
================

// Module: fd_pipe_reg
// PURPOSE
//  F->D pipeline register of the 5-stage MIPS core. Captures the fetched word,
//  PC, fetch exception code and delay-slot flag each cycle. Presents them to the
//  D stage with decoded field taps; imm16 drives the D-stage immediate extender.
//  Implements stall (hold), flush (bubble) and exception redirect (req).
// PARAMETERS
//  RESET_PC    32'h0000_3000  D_pc value after reset
//  HANDLER_PC  32'h0000_4180  D_pc value loaded on req (exception entry)
//  NOP_INSTR   32'h0000_0000  word loaded into D_instr on bubble/reset/req
// PORTS
//  clk        in   1   core clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  req        in   1   exception/interrupt redirect from CP0, highest priority
//  stall      in   1   hazard-unit stall: hold all state
//  flush      in   1   insert bubble (e.g. cancelled slot after eret)
//  F_pc       in   32  PC of fetched word
//  F_instr    in   32  fetched instruction word
//  F_exccode  in   5   fetch-stage exception code (0 = none)
//  F_bd       in   1   fetched word is in a branch delay slot
//  D_pc       out  32  registered PC
//  D_instr    out  32  registered instruction
//  D_exccode  out  5   registered exception code
//  D_bd       out  1   registered delay-slot flag
//  D_valid    out  1   1 = real instruction, 0 = bubble
//  D_rs       out  5   D_instr[25:21]
//  D_rt       out  5   D_instr[20:16]
//  D_rd       out  5   D_instr[15:11]
//  D_imm16    out  16  D_instr[15:0], to the immediate extender
// BEHAVIOUR
//  - Reset (async, any time): D_pc=RESET_PC, D_instr=NOP_INSTR, D_exccode=0,
//    D_bd=0, D_valid=0. Released state loads on first rising edge after deassert.
//  - Per rising edge, priority req > stall > flush > load:
//    req:   D_pc=HANDLER_PC, D_instr=NOP_INSTR, D_exccode=0, D_bd=0, D_valid=0.
//           req overrides a concurrent stall (pipeline must drain into handler).
//    stall: all registers hold; flush during stall is ignored (no bubble).
//    flush: D_pc=F_pc, D_instr=NOP_INSTR, D_exccode=0, D_bd=0, D_valid=0.
//    load:  D_*=F_*, D_valid=1.
//  - Latency 1 cycle F->D; field taps (D_rs..D_imm16) combinational from D_instr.
//  - D_pc of a bubble stays meaningful (flush keeps F_pc) so CP0 EPC is correct
//    when an interrupt hits while a bubble is in D.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  FD_FETCH_EXC_CHECK_EN defined: on load, if F_pc[1:0]!=0 or F_pc outside
//    [32'h0000_3000, 32'h0000_6ffc], D_exccode=5'd4 (AdEL), D_instr=NOP_INSTR,
//    D_valid=1 (the faulting slot must still reach CP0); F_exccode is ignored
//    for that slot. Check applied only on the load path.
//  Not defined: no address check; D_exccode is always F_exccode on load.
// TESTING
//  1 reset asserted mid-cycle with D loaded -> outputs go to reset values
//    immediately (no clock), D_pc=32'h3000, D_valid=0.
//  2 load F_pc=32'h3004, F_instr=32'h3c01_1234 -> next edge D_pc=32'h3004,
//    D_rt=5'd1, D_imm16=16'h1234, D_valid=1.
//  3 stall=1 for 3 cycles with changing F_* -> D_* unchanged; stall+flush same
//    cycle -> no bubble; deassert -> loads current F_*.
//  4 flush=1, F_pc=32'h3010 -> D_instr=0, D_pc=32'h3010, D_valid=0, D_bd=0.
//  5 req=1 with stall=1, F_bd=1 -> D_pc=32'h4180, D_instr=0, D_bd=0, D_valid=0.
//  6 (FD_FETCH_EXC_CHECK_EN) F_pc=32'h3002, then 32'h7000 -> D_exccode=4,
//    D_instr=0, D_valid=1; F_pc=32'h6ffc -> D_exccode=F_exccode.

Source files
------------

// File: rtl/fd_pipe_reg.sv
// -----------------------------------------------------------------------------
// fd_pipe_reg
//
// Purpose:
//   F->D pipeline register of the 5-stage MIPS core. Captures the fetched
//   word, its PC, the fetch exception code and the delay-slot flag on every
//   rising clock edge, and presents them to the D stage together with
//   decoded register/immediate field taps. Supports hold (stall), bubble
//   insertion (flush) and exception redirect (req).
//
//   Per-edge priority: req > stall > flush > load.
//
// Configuration:
//   FD_FETCH_EXC_CHECK_EN - when defined, the load path checks F_pc for
//   misalignment or an address outside the text segment and turns such a
//   slot into an AdEL (exccode 4) with a NOP word, still marked valid so the
//   fault reaches CP0. When undefined, F_exccode is passed through unchanged.
//
// Ports:
//   clk        in   1   core clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   req        in   1   exception/interrupt redirect from CP0 (highest priority)
//   stall      in   1   hold all state
//   flush      in   1   insert a bubble
//   F_pc       in   32  PC of fetched word
//   F_instr    in   32  fetched instruction word
//   F_exccode  in   5   fetch exception code (0 = none)
//   F_bd       in   1   fetched word is in a branch delay slot
//   D_pc       out  32  registered PC
//   D_instr    out  32  registered instruction
//   D_exccode  out  5   registered exception code
//   D_bd       out  1   registered delay-slot flag
//   D_valid    out  1   1 = real instruction, 0 = bubble
//   D_rs       out  5   D_instr[25:21]
//   D_rt       out  5   D_instr[20:16]
//   D_rd       out  5   D_instr[15:11]
//   D_imm16    out  16  D_instr[15:0]
// -----------------------------------------------------------------------------
module fd_pipe_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic [4:0]  F_exccode,
    input  logic        F_bd,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic        D_valid,
    output logic [4:0]  D_rs,
    output logic [4:0]  D_rt,
    output logic [4:0]  D_rd,
    output logic [15:0] D_imm16
);

`ifdef FD_FETCH_EXC_CHECK_EN
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI    = 32'h0000_6ffc;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
`endif

    logic [31:0] pc_q,      pc_d;
    logic [31:0] instr_q,   instr_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        bd_q,      bd_d;
    logic        valid_q,   valid_d;

`ifdef FD_FETCH_EXC_CHECK_EN
    logic addr_bad;
    assign addr_bad = (F_pc[1:0] != 2'b00) || (F_pc < TEXT_LO) || (F_pc > TEXT_HI);
`endif

    // Next-state selection in priority order req > stall > flush > load.
    always_comb begin
        // NOTE: every signal gets a default (hold) first so no path leaves
        // it unassigned -- that is what keeps this block from inferring latches.
        pc_d      = pc_q;
        instr_d   = instr_q;
        exccode_d = exccode_q;
        bd_d      = bd_q;
        valid_d   = valid_q;

        if (req) begin
            // Redirect wins even over stall so the pipeline drains into the handler.
            pc_d      = HANDLER_PC;
            instr_d   = NOP_INSTR;
            exccode_d = 5'd0;
            bd_d      = 1'b0;
            valid_d   = 1'b0;
        end else if (stall) begin
            // Hold: defaults already carry the current state; flush is ignored.
        end else if (flush) begin
            // Bubble keeps F_pc so EPC is correct if an interrupt lands on it.
            pc_d      = F_pc;
            instr_d   = NOP_INSTR;
            exccode_d = 5'd0;
            bd_d      = 1'b0;
            valid_d   = 1'b0;
        end else begin
            pc_d      = F_pc;
            instr_d   = F_instr;
            exccode_d = F_exccode;
            bd_d      = F_bd;
            valid_d   = 1'b1;
`ifdef FD_FETCH_EXC_CHECK_EN
            // Faulting fetch: drop the word but keep the slot valid for CP0.
            if (addr_bad) begin
                instr_d   = NOP_INSTR;
                exccode_d = EXC_ADEL;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // same pre-edge values, independent of statement order.
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            exccode_q <= exccode_d;
            bd_q      <= bd_d;
            valid_q   <= valid_d;
        end
    end

    assign D_pc      = pc_q;
    assign D_instr   = instr_q;
    assign D_exccode = exccode_q;
    assign D_bd      = bd_q;
    assign D_valid   = valid_q;

    // Field taps decode straight from the register, so no input reaches them combinationally.
    assign D_rs    = instr_q[25:21];
    assign D_rt    = instr_q[20:16];
    assign D_rd    = instr_q[15:11];
    assign D_imm16 = instr_q[15:0];

endmodule
